dec_gpr_bank_ctl: RTL and testbench

Parametrised multi-bank integer register file for the decode stage. It generalises the single-bank GPR array: read/write port counts, data width and bank count are all parameters, and it adds priority write-conflict resolution and an optional same-cycle write-to-read bypass. A bank-switch state machine either switches the active bank in one cycle or copies the active bank into the target bank over 31 cycles before switching.

---
 rtl/dec_gpr_pkg.sv | 13 +
 rtl/dec_gpr_bank_ctl_if.sv | 33 +++
 rtl/dec_gpr_wr_arb.sv | 33 +++
 rtl/rvdff.sv | 17 +
 rtl/rvdffe.sv | 19 +
 rtl/rvdffs.sv | 18 +
 rtl/dec_gpr_bank_ctl.sv | 167 ++++++++++++++++
 tb/tb_dec_gpr_bank_ctl.sv | 260 ++++++++++++++++++++++++++
 8 files changed

// File: rtl/dec_gpr_pkg.sv
// Shared types and constants for the decode-stage GPR bank controller.
// Latency: n/a (types only); backpressure: n/a.
package dec_gpr_pkg;

    localparam int GPR_NUM = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } bank_fsm_e;

endpackage

// File: rtl/dec_gpr_bank_ctl_if.sv
// Read/write port and bank-switch bundle between the decode stage and the GPR bank controller.
// Latency: n/a (wires only); backpressure: none, all transfers are fire-and-forget.
interface dec_gpr_bank_ctl_if #(
    parameter int XLEN           = 64,
    parameter int NRD            = 4,
    parameter int NWR            = 3,
    parameter int GPR_BANKS_LOG2 = 1
);
    logic [NRD-1:0][4:0]            raddr;
    logic [NRD-1:0]                 rden;
    logic [NRD-1:0][XLEN-1:0]       rd;
    logic [NWR-1:0][4:0]            waddr;
    logic [NWR-1:0]                 wen;
    logic [NWR-1:0][XLEN-1:0]       wd;
    logic                           bank_sw_req;
    logic [GPR_BANKS_LOG2-1:0]      bank_sw_id;
    logic                           bank_sw_copy;
    logic [GPR_BANKS_LOG2-1:0]      cur_bank;
    logic                           bank_busy;
    logic                           bank_sw_done;
    logic                           wr_conflict;

    modport master (
        output raddr, rden, waddr, wen, wd, bank_sw_req, bank_sw_id, bank_sw_copy,
        input  rd, cur_bank, bank_busy, bank_sw_done, wr_conflict
    );

    modport slave (
        input  raddr, rden, waddr, wen, wd, bank_sw_req, bank_sw_id, bank_sw_copy,
        output rd, cur_bank, bank_busy, bank_sw_done, wr_conflict
    );

endinterface

// File: rtl/dec_gpr_wr_arb.sv
// Per-address write select across all write ports; lowest-numbered port wins, x0 never hits.
// Latency: combinational; backpressure: none.
module dec_gpr_wr_arb
    import dec_gpr_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NWR  = 3
) (
    input  logic [NWR-1:0][4:0]          waddr,
    input  logic [NWR-1:0]               wen,
    input  logic [NWR-1:0][XLEN-1:0]     wd,
    output logic [GPR_NUM-1:0]           hit,
    output logic [GPR_NUM-1:0][XLEN-1:0] sel_wd,
    output logic                         conflict
);

    // Walk ports high-to-low so the lowest port's data is the last one assigned.
    always_comb begin
        hit      = '0;
        sel_wd   = '0;
        conflict = 1'b0;
        for (int a = 1; a < GPR_NUM; a++) begin
            for (int p = NWR - 1; p >= 0; p--) begin
                if (wen[p] && (waddr[p] == 5'(a))) begin
                    conflict  = conflict | hit[a];
                    hit[a]    = 1'b1;
                    sel_wd[a] = wd[p];
                end
            end
        end
    end

endmodule

// File: rtl/rvdff.sv
// Plain reset flop, WIDTH bits.
// Latency: 1 cycle; backpressure: none.
module rvdff #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             clk,
    input  logic             rst_l,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) dout <= '0;
        else        dout <= din;
    end

endmodule

// File: rtl/rvdffe.sv
// Clock-gated reset flop: the enable models the gate, scan_mode forces the gate open.
// Latency: 1 cycle; backpressure: none, holds value while the gate is closed.
module rvdffe #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             clk,
    input  logic             rst_l,
    input  logic             scan_mode,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)                dout <= '0;
        else if (en || scan_mode)  dout <= din;
    end

endmodule

// File: rtl/rvdffs.sv
// Reset flop with load enable, WIDTH bits.
// Latency: 1 cycle; backpressure: none, holds value while en is low.
module rvdffs #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             clk,
    input  logic             rst_l,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)  dout <= '0;
        else if (en) dout <= din;
    end

endmodule

// File: rtl/dec_gpr_bank_ctl.sv
// Multi-bank GPR file with priority write arbitration, optional bypass and a bank copy/switch FSM.
// Latency: reads combinational, writes visible next cycle, copy switch 31 cycles; backpressure: none, switch requests outside IDLE are dropped.
module dec_gpr_bank_ctl
    import dec_gpr_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int NRD            = 4,
    parameter int NWR            = 3,
    parameter int GPR_BANKS      = 2,
    parameter int GPR_BANKS_LOG2 = 1,
    parameter int BYPASS         = 0
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                scan_mode,
    dec_gpr_bank_ctl_if.slave   io
);

    localparam logic [GPR_BANKS_LOG2:0] BANK_CNT = (GPR_BANKS_LOG2 + 1)'(GPR_BANKS);
    localparam logic [4:0]              IDX_LAST = 5'(GPR_NUM - 1);

    logic [GPR_NUM-1:0]             hit;
    logic [GPR_NUM-1:0][XLEN-1:0]   sel_wd;
    logic                           conflict;
    logic                           conflict_q;

    logic [XLEN-1:0]                gpr [GPR_BANKS][GPR_NUM];
    logic [GPR_NUM-1:1][XLEN-1:0]   gpr_din;
    logic [GPR_NUM-1:1]             gpr_we [GPR_BANKS];

    bank_fsm_e                      state;
    bank_fsm_e                      state_nxt;
    logic [1:0]                     state_raw;
    logic [4:0]                     idx;
    logic [4:0]                     idx_nxt;
    logic [4:0]                     idx_enc;
    logic [GPR_BANKS_LOG2-1:0]      cur_bank;
    logic [GPR_BANKS_LOG2-1:0]      cur_nxt;
    logic [GPR_BANKS_LOG2-1:0]      tgt;
    logic                           cur_en;
    logic                           start_copy;
    logic                           sw_same;
    logic                           copying;
    logic [NRD-1:0][XLEN-1:0]       rd_dat;

    dec_gpr_wr_arb #(
        .XLEN (XLEN),
        .NWR  (NWR)
    ) u_wr_arb (
        .waddr    (io.waddr),
        .wen      (io.wen),
        .wd       (io.wd),
        .hit      (hit),
        .sel_wd   (sel_wd),
        .conflict (conflict)
    );

    // Out-of-range targets fall into the same-bank path: done pulse, no change.
    assign sw_same = (io.bank_sw_id == cur_bank) || ({1'b0, io.bank_sw_id} >= BANK_CNT);
    assign copying = (state == COPY);

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cur_nxt    = cur_bank;
        cur_en     = 1'b0;
        start_copy = 1'b0;
        case (state)
            IDLE: begin
                if (io.bank_sw_req) begin
                    if (sw_same) begin
                        state_nxt = DONE;
                    end else if (!io.bank_sw_copy) begin
                        cur_en    = 1'b1;
                        cur_nxt   = io.bank_sw_id;
                        state_nxt = DONE;
                    end else begin
                        start_copy = 1'b1;
                        idx_nxt    = 5'd1;
                        state_nxt  = COPY;
                    end
                end
            end
            COPY: begin
                if (idx == IDX_LAST) begin
                    cur_en    = 1'b1;
                    cur_nxt   = tgt;
                    idx_nxt   = 5'd1;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + 5'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    rvdff #(.WIDTH(2)) u_state (
        .din (state_nxt), .clk (clk), .rst_l (rst_l), .dout (state_raw)
    );
    assign state = bank_fsm_e'(state_raw);

    // Stored XOR 1 so the all-zero reset state decodes to index 1.
    rvdff #(.WIDTH(5)) u_idx (
        .din (idx_nxt ^ 5'd1), .clk (clk), .rst_l (rst_l), .dout (idx_enc)
    );
    assign idx = idx_enc ^ 5'd1;

    rvdffs #(.WIDTH(GPR_BANKS_LOG2)) u_cur (
        .din (cur_nxt), .en (cur_en), .clk (clk), .rst_l (rst_l), .dout (cur_bank)
    );

    rvdffs #(.WIDTH(GPR_BANKS_LOG2)) u_tgt (
        .din (io.bank_sw_id), .en (start_copy), .clk (clk), .rst_l (rst_l), .dout (tgt)
    );

    rvdff #(.WIDTH(1)) u_conflict (
        .din (conflict), .clk (clk), .rst_l (rst_l), .dout (conflict_q)
    );

    // Port writes land in the active bank and, while copying, are mirrored into the target;
    // a port write to the register being copied takes precedence over the copied value.
    always_comb begin
        gpr_din = '0;
        for (int b = 0; b < GPR_BANKS; b++) gpr_we[b] = '0;
        for (int i = 1; i < GPR_NUM; i++) begin
            gpr_din[i] = hit[i] ? sel_wd[i] : gpr[cur_bank][i];
            for (int b = 0; b < GPR_BANKS; b++) begin
                gpr_we[b][i] = (hit[i] && ((cur_bank == GPR_BANKS_LOG2'(b)) ||
                                           (copying && (tgt == GPR_BANKS_LOG2'(b))))) ||
                               (copying && (tgt == GPR_BANKS_LOG2'(b)) && (idx == 5'(i)));
            end
        end
    end

    for (genvar b = 0; b < GPR_BANKS; b++) begin : g_bank
        assign gpr[b][0] = '0;
        for (genvar i = 1; i < GPR_NUM; i++) begin : g_reg
            rvdffe #(.WIDTH(XLEN)) u_gpr (
                .din       (gpr_din[i]),
                .en        (gpr_we[b][i]),
                .clk       (clk),
                .rst_l     (rst_l),
                .scan_mode (scan_mode),
                .dout      (gpr[b][i])
            );
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int k = 0; k < NRD; k++) begin
            if (io.rden[k] && (io.raddr[k] != 5'd0)) begin
                rd_dat[k] = gpr[cur_bank][io.raddr[k]];
                if ((BYPASS != 0) && hit[io.raddr[k]]) rd_dat[k] = sel_wd[io.raddr[k]];
            end
        end
    end

    assign io.rd           = rd_dat;
    assign io.cur_bank     = cur_bank;
    assign io.bank_busy    = copying;
    assign io.bank_sw_done = (state == DONE);
    assign io.wr_conflict  = conflict_q;

endmodule

// File: tb/tb_dec_gpr_bank_ctl.sv
// Scoreboard bench for dec_gpr_bank_ctl: one DUT without and one with bypass, driven identically.
module tb_dec_gpr_bank_ctl;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic scan_mode = 1'b0;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mdl [2][32];

    dec_gpr_bank_ctl_if #(.XLEN(64), .NRD(4), .NWR(3), .GPR_BANKS_LOG2(1)) io0 ();
    dec_gpr_bank_ctl_if #(.XLEN(64), .NRD(4), .NWR(3), .GPR_BANKS_LOG2(1)) io1 ();

    assign io1.raddr        = io0.raddr;
    assign io1.rden         = io0.rden;
    assign io1.waddr        = io0.waddr;
    assign io1.wen          = io0.wen;
    assign io1.wd           = io0.wd;
    assign io1.bank_sw_req  = io0.bank_sw_req;
    assign io1.bank_sw_id   = io0.bank_sw_id;
    assign io1.bank_sw_copy = io0.bank_sw_copy;

    dec_gpr_bank_ctl #(.XLEN(64), .NRD(4), .NWR(3), .GPR_BANKS(2), .GPR_BANKS_LOG2(1), .BYPASS(0))
        dut0 (.clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .io(io0));
    dec_gpr_bank_ctl #(.XLEN(64), .NRD(4), .NWR(3), .GPR_BANKS(2), .GPR_BANKS_LOG2(1), .BYPASS(1))
        dut1 (.clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .io(io1));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        io0.raddr = '0; io0.rden = '0;
        io0.waddr = '0; io0.wen = '0; io0.wd = '0;
        io0.bank_sw_req = 1'b0; io0.bank_sw_id = '0; io0.bank_sw_copy = 1'b0;
    endtask

    task automatic put(input int p, input int a, input logic [63:0] d);
        io0.waddr[p] = 5'(a); io0.wen[p] = 1'b1; io0.wd[p] = d;
    endtask

    task automatic rd_push(input int p, input int a, input logic [63:0] e);
        io0.raddr[p] = 5'(a); io0.rden[p] = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic clear_model();
        for (int b = 0; b < 2; b++) for (int i = 0; i < 32; i++) mdl[b][i] = '0;
    endtask

    task automatic test_reset();
        logic [63:0] e;
        idle_in(); rst_l = 1'b0; clear_model();
        repeat (2) @(posedge clk);
        #1;
        total++; if (io0.cur_bank !== 1'b0) begin bad++; $display("FAIL reset_cur_bank got=%0d exp=0", io0.cur_bank); end
        total++; if (io0.bank_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", io0.bank_busy); end
        total++; if (io0.bank_sw_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", io0.bank_sw_done); end
        total++; if (io0.wr_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%b exp=0", io0.wr_conflict); end
        #2 rst_l = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) rd_push(k, 5 + k, 64'h0);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); total++;
            if (io0.rd[k] !== e) begin bad++; $display("FAIL reset_read port%0d got=%h exp=%h", k, io0.rd[k], e); end
        end
    endtask

    task automatic test_basic_rw();
        logic [63:0] e;
        idle_in(); put(0, 5, 64'h1234); mdl[0][5] = 64'h1234;
        tick();
        idle_in();
        for (int k = 0; k < 4; k++) rd_push(k, 5, mdl[0][5]);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); total++;
            if (io0.rd[k] !== e) begin bad++; $display("FAIL rw_x5 port%0d got=%h exp=%h", k, io0.rd[k], e); end
        end
        tick();
        idle_in(); put(1, 0, 64'hFF);
        tick();
        idle_in();
        rd_push(0, 0, 64'h0);
        rd_push(1, 5, 64'h1234);
        io0.raddr[2] = 5'd5; exp_q.push_back(64'h0);
        rd_push(3, 0, 64'h0);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); total++;
            if (io0.rd[k] !== e) begin bad++; $display("FAIL rw_x0_rden port%0d got=%h exp=%h", k, io0.rd[k], e); end
        end
        tick();
    endtask

    task automatic test_conflict();
        logic [63:0] e;
        idle_in(); put(0, 7, 64'hA); put(2, 7, 64'hB); mdl[0][7] = 64'hA;
        tick();
        idle_in(); rd_push(0, 7, mdl[0][7]);
        #1;
        total++; if (io0.wr_conflict !== 1'b1) begin bad++; $display("FAIL conflict_set got=%b exp=1", io0.wr_conflict); end
        e = exp_q.pop_front(); total++;
        if (io0.rd[0] !== e) begin bad++; $display("FAIL conflict_prio got=%h exp=%h", io0.rd[0], e); end
        tick();
        total++; if (io0.wr_conflict !== 1'b0) begin bad++; $display("FAIL conflict_clear got=%b exp=0", io0.wr_conflict); end
        put(0, 0, 64'h1); put(1, 0, 64'h2);
        tick();
        idle_in();
        total++; if (io0.wr_conflict !== 1'b0) begin bad++; $display("FAIL conflict_x0 got=%b exp=0", io0.wr_conflict); end
        tick();
    endtask

    task automatic test_bypass();
        logic [63:0] e;
        idle_in(); put(0, 3, 64'h11); mdl[0][3] = 64'h11;
        tick();
        idle_in(); put(1, 3, 64'h55);
        rd_push(0, 3, mdl[0][3]); exp_q.push_back(64'h55);
        #1;
        e = exp_q.pop_front(); total++;
        if (io0.rd[0] !== e) begin bad++; $display("FAIL bypass_off got=%h exp=%h", io0.rd[0], e); end
        e = exp_q.pop_front(); total++;
        if (io1.rd[0] !== e) begin bad++; $display("FAIL bypass_on got=%h exp=%h", io1.rd[0], e); end
        mdl[0][3] = 64'h55;
        tick();
        idle_in(); put(0, 3, 64'h66); put(2, 3, 64'h77);
        rd_push(1, 3, mdl[0][3]); exp_q.push_back(64'h66);
        #1;
        e = exp_q.pop_front(); total++;
        if (io0.rd[1] !== e) begin bad++; $display("FAIL bypass_off_prio got=%h exp=%h", io0.rd[1], e); end
        e = exp_q.pop_front(); total++;
        if (io1.rd[1] !== e) begin bad++; $display("FAIL bypass_on_prio got=%h exp=%h", io1.rd[1], e); end
        mdl[0][3] = 64'h66;
        tick();
        idle_in(); rd_push(2, 3, mdl[0][3]);
        #1;
        e = exp_q.pop_front(); total++;
        if (io0.rd[2] !== e) begin bad++; $display("FAIL bypass_stored got=%h exp=%h", io0.rd[2], e); end
        tick();
    endtask

    task automatic test_copy();
        logic [63:0] e;
        for (int i = 1; i < 32; i += 3) begin
            idle_in();
            for (int p = 0; p < 3; p++) if (i + p < 32) begin put(p, i + p, 64'(i + p)); mdl[0][i + p] = 64'(i + p); end
            tick();
        end
        idle_in(); io0.bank_sw_req = 1'b1; io0.bank_sw_id = 1'b1; io0.bank_sw_copy = 1'b1;
        tick();
        for (int c = 1; c <= 31; c++) begin
            idle_in();
            rd_push(3, c, mdl[0][c]);
            if (c == 5) begin io0.bank_sw_req = 1'b1; io0.bank_sw_id = 1'b0; io0.bank_sw_copy = 1'b0; end
            if (c == 10) begin put(0, 20, 64'hDEAD); mdl[0][20] = 64'hDEAD; end
            if (c == 12) begin put(1, 12, 64'hBEEF); mdl[0][12] = 64'hBEEF; end
            #1;
            total++; if (io0.bank_busy !== 1'b1) begin bad++; $display("FAIL copy_busy cycle%0d got=%b exp=1", c, io0.bank_busy); end
            e = exp_q.pop_front(); total++;
            if (io0.rd[3] !== e) begin bad++; $display("FAIL copy_src_read cycle%0d got=%h exp=%h", c, io0.rd[3], e); end
            tick();
        end
        idle_in();
        for (int i = 0; i < 32; i++) mdl[1][i] = mdl[0][i];
        total++; if (io0.bank_busy !== 1'b0) begin bad++; $display("FAIL copy_busy_end got=%b exp=0", io0.bank_busy); end
        total++; if (io0.bank_sw_done !== 1'b1) begin bad++; $display("FAIL copy_done got=%b exp=1", io0.bank_sw_done); end
        total++; if (io0.cur_bank !== 1'b1) begin bad++; $display("FAIL copy_bank got=%0d exp=1", io0.cur_bank); end
        tick();
        total++; if (io0.bank_sw_done !== 1'b0) begin bad++; $display("FAIL copy_done_pulse got=%b exp=0", io0.bank_sw_done); end
        total++; if (io0.cur_bank !== 1'b1) begin bad++; $display("FAIL copy_ignore_req got=%0d exp=1", io0.cur_bank); end
        for (int i = 1; i < 32; i += 4) begin
            idle_in();
            for (int k = 0; k < 4; k++) rd_push(k, (i + k < 32) ? i + k : 0, (i + k < 32) ? mdl[1][i + k] : 64'h0);
            #1;
            for (int k = 0; k < 4; k++) begin
                e = exp_q.pop_front(); total++;
                if (io0.rd[k] !== e) begin bad++; $display("FAIL copy_bank1 x%0d got=%h exp=%h", i + k, io0.rd[k], e); end
            end
            tick();
        end
        idle_in();
    endtask

    task automatic test_switch();
        logic [63:0] e;
        idle_in(); io0.bank_sw_req = 1'b1; io0.bank_sw_id = 1'b1; io0.bank_sw_copy = 1'b1;
        tick();
        idle_in();
        total++; if (io0.bank_sw_done !== 1'b1) begin bad++; $display("FAIL same_done got=%b exp=1", io0.bank_sw_done); end
        total++; if (io0.bank_busy !== 1'b0) begin bad++; $display("FAIL same_busy got=%b exp=0", io0.bank_busy); end
        total++; if (io0.cur_bank !== 1'b1) begin bad++; $display("FAIL same_bank got=%0d exp=1", io0.cur_bank); end
        tick();
        io0.bank_sw_req = 1'b1; io0.bank_sw_id = 1'b0; io0.bank_sw_copy = 1'b0;
        tick();
        idle_in();
        total++; if (io0.cur_bank !== 1'b0) begin bad++; $display("FAIL plain_bank got=%0d exp=0", io0.cur_bank); end
        total++; if (io0.bank_sw_done !== 1'b1) begin bad++; $display("FAIL plain_done got=%b exp=1", io0.bank_sw_done); end
        rd_push(0, 20, mdl[0][20]); rd_push(1, 12, mdl[0][12]); rd_push(2, 1, mdl[0][1]); rd_push(3, 31, mdl[0][31]);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); total++;
            if (io0.rd[k] !== e) begin bad++; $display("FAIL plain_bank0_read port%0d got=%h exp=%h", k, io0.rd[k], e); end
        end
        tick();
        idle_in(); io0.bank_sw_req = 1'b1; io0.bank_sw_id = 1'b1;
        tick();
        idle_in();
        tick();
    endtask

    task automatic test_reset_mid_copy();
        logic [63:0] e;
        idle_in(); io0.bank_sw_req = 1'b1; io0.bank_sw_id = 1'b0; io0.bank_sw_copy = 1'b1;
        tick();
        idle_in();
        repeat (14) tick();
        total++; if (io0.bank_busy !== 1'b1 || io0.cur_bank !== 1'b1) begin
            bad++; $display("FAIL midcopy_pre busy=%b bank=%0d exp busy=1 bank=1", io0.bank_busy, io0.cur_bank);
        end
        rst_l = 1'b0; clear_model();
        rd_push(0, 20, 64'h0); rd_push(1, 12, 64'h0); rd_push(2, 1, 64'h0); rd_push(3, 15, 64'h0);
        #1;
        total++; if (io0.cur_bank !== 1'b0) begin bad++; $display("FAIL midcopy_bank got=%0d exp=0", io0.cur_bank); end
        total++; if (io0.bank_busy !== 1'b0) begin bad++; $display("FAIL midcopy_busy got=%b exp=0", io0.bank_busy); end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); total++;
            if (io0.rd[k] !== e) begin bad++; $display("FAIL midcopy_read port%0d got=%h exp=%h", k, io0.rd[k], e); end
        end
        #1 rst_l = 1'b1;
        tick();
        total++; if (io0.bank_busy !== 1'b0) begin bad++; $display("FAIL midcopy_after got=%b exp=0", io0.bank_busy); end
    endtask

    initial begin
        idle_in();
        test_reset();
        test_basic_rw();
        test_conflict();
        test_bypass();
        test_copy();
        test_switch();
        test_reset_mid_copy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
